// File: rtl/ahb_slave_ctrl_if.sv
// ahb_slave_ctrl_if: AHB-Lite slave bus plus FIFO flags and register/FIFO access strobes.
interface ahb_slave_ctrl_if #(
  parameter int ADDR_W   = 7,
  parameter int SR_BYTES = 2,
  parameter int ER_BYTES = 2
);
  logic                hsel;
  logic [1:0]          htrans;
  logic [ADDR_W-1:0]   haddr;
  logic [2:0]          hsize;
  logic                hwrite;
  logic                hready;
  logic                rx_empty;
  logic                tx_full;
  logic                hready_out;
  logic                hresp;
  logic                get_rx_data;
  logic                store_tx_data;
  logic [SR_BYTES-1:0] sr_read;
  logic [ER_BYTES-1:0] er_read;
  logic                bo_read;
  logic                ts_read;
  logic                ts_write;
  modport master (
    output hsel, htrans, haddr, hsize, hwrite, hready, rx_empty, tx_full,
    input  hready_out, hresp, get_rx_data, store_tx_data, sr_read, er_read, bo_read, ts_read, ts_write
  );
  modport slave (
    input  hsel, htrans, haddr, hsize, hwrite, hready, rx_empty, tx_full,
    output hready_out, hresp, get_rx_data, store_tx_data, sr_read, er_read, bo_read, ts_read, ts_write
  );
endinterface

// File: rtl/ahb_slave_ctrl.sv
// ahb_slave_ctrl: AHB-Lite slave front-end decoding CSR/FIFO accesses into one-cycle strobes.
// Optional wait-state timeout to ERROR is enabled by defining AHB_WAIT_TIMEOUT_EN.
module ahb_slave_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int SR_BYTES = 2,
  parameter int ER_BYTES = 2,
  parameter int SR_OFF   = 0,
  parameter int ER_OFF   = 2,
  parameter int BO_OFF   = 4,
  parameter int TS_OFF   = 8,
  parameter int WAIT_MAX = 15
) (
  input logic clk,
  input logic n_rst,
  ahb_slave_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, DATA = 3'd1, WAIT = 3'd2, ERR1 = 3'd3, ERR2 = 3'd4;
  logic [2:0] state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [2:0] size;
  logic wr, csr, acc, err, blocked, done, rd_csr;
  logic [SR_BYTES-1:0] sr_v;
  logic [ER_BYTES-1:0] er_v;
  logic bo_v, ts_v;
  // A CSR access is legal only if every covered byte lands on a mapped register byte
  always_comb begin
    int o, nb;
    o = int'(addr[ADDR_W-2:0]);
    nb = 1 << size[1:0];
    for (int i = 0; i < SR_BYTES; i++) sr_v[i] = SR_OFF + i >= o && SR_OFF + i < o + nb;
    for (int i = 0; i < ER_BYTES; i++) er_v[i] = ER_OFF + i >= o && ER_OFF + i < o + nb;
    bo_v = BO_OFF >= o && BO_OFF < o + nb;
    ts_v = TS_OFF >= o && TS_OFF < o + nb;
    err = size > 3'd2 || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'd0)
      || (csr && (wr ? !(size == 3'd0 && o == TS_OFF) : $countones({sr_v, er_v, bo_v, ts_v}) != nb));
  end
  assign csr = addr[ADDR_W-1];
  assign blocked = !csr && (wr ? bus.tx_full : bus.rx_empty);
  assign done = (state == DATA && !err && !blocked) || (state == WAIT && !blocked);
  assign rd_csr = done && csr && !wr;
  assign bus.hready_out = state == IDLE || state == ERR2 || done;
  assign bus.hresp = state == ERR1 || state == ERR2;
  assign acc = bus.hsel && bus.htrans[1] && bus.hready && bus.hready_out;
  assign bus.get_rx_data = done && !csr && !wr;
  assign bus.store_tx_data = done && !csr && wr;
  assign bus.sr_read = rd_csr ? sr_v : '0;
  assign bus.er_read = rd_csr ? er_v : '0;
  assign bus.bo_read = rd_csr && bo_v;
  assign bus.ts_read = rd_csr && ts_v;
  assign bus.ts_write = done && csr && wr;
`ifdef AHB_WAIT_TIMEOUT_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else cnt <= cnt_n;
`endif
  always_comb begin
    state_n = bus.hready_out ? (acc ? DATA : IDLE)
      : state == ERR1 ? ERR2
      : state == DATA && err ? ERR1 : WAIT;
`ifdef AHB_WAIT_TIMEOUT_EN
    cnt_n = state == WAIT && !done ? cnt + 1'b1 : '0;
    if (cnt_n == CW'(WAIT_MAX)) state_n = ERR1;
`endif
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      addr <= '0;
      size <= '0;
      wr <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        addr <= bus.haddr;
        size <= bus.hsize;
        wr <= bus.hwrite;
      end
    end
endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// tb_ahb_slave_ctrl: directed plus randomized transfers checked against a transfer-level model.
module tb_ahb_slave_ctrl;
  typedef struct packed {logic v; logic [6:0] a; logic [2:0] s; logic w; logic [2:0] stall;} xfer_t;
  logic clk = 1'b0, n_rst = 1'b0;
  int checks = 0, errors = 0;
  xfer_t pend;
  logic [8:0] strobes;
  ahb_slave_ctrl_if bus();
  ahb_slave_ctrl dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.hready = bus.hready_out;
  assign strobes = {bus.get_rx_data, bus.store_tx_data, bus.sr_read, bus.er_read, bus.bo_read, bus.ts_read, bus.ts_write};

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-by-byte walk of the CSR map: SR 0..1, ER 2..3, BO 4, TS 8
  function automatic logic [8:0] model(input xfer_t t, output logic ill);
    int nb, off;
    logic rx, tx, bo, tsr, tsw;
    logic [1:0] sr, er;
    {rx, tx, bo, tsr, tsw, sr, er} = '0;
    nb = 1 << t.s;
    off = int'(t.a[5:0]);
    ill = t.s > 3'd2 || int'(t.a) % nb != 0;
    if (!t.a[6]) begin
      rx = !t.w;
      tx = t.w;
    end else begin
      for (int b = off; b < off + nb; b++)
        if (b < 2) sr |= 2'(1 << b);
        else if (b < 4) er |= 2'(1 << (b - 2));
        else if (b == 4) bo = 1'b1;
        else if (b == 8) begin tsr = !t.w; tsw = t.w; end
        else ill = 1'b1;
      if (t.w && !(t.s == 3'd0 && off == 8)) ill = 1'b1;
      if (t.w) begin sr = '0; er = '0; bo = 1'b0; end
    end
    return {rx, tx, sr, er, bo, tsr, tsw};
  endfunction

  function automatic xfer_t mk(input logic [6:0] a, input logic [2:0] s, input logic w, input logic [2:0] stall);
    return {1'b1, a, s, w, stall};
  endfunction

  task automatic cyc(input string tag, input logic hr, input logic hp, input logic [8:0] st);
    #2;
    chk({tag, " hready_out"}, 9'(bus.hready_out), 9'(hr));
    chk({tag, " hresp"}, 9'(bus.hresp), 9'(hp));
    chk({tag, " strobes"}, strobes, st);
    @(posedge clk);
    #1;
  endtask

  // Drive n as the address phase while running the data phase of the pending transfer
  task automatic issue(input xfer_t n);
    logic ill;
    logic [8:0] e;
    bus.hsel = n.v ? 1'b1 : 1'($urandom_range(0, 1));
    bus.htrans = n.v ? {1'b1, 1'($urandom_range(0, 1))} : bus.hsel ? {1'b0, 1'($urandom_range(0, 1))} : 2'($urandom);
    bus.haddr = n.a;
    bus.hsize = n.s;
    bus.hwrite = n.w;
    e = model(pend, ill);
    if (!pend.v) begin
      bus.rx_empty = 1'($urandom);
      bus.tx_full = 1'($urandom);
      cyc("idle", 1'b1, 1'b0, '0);
    end else if (ill) begin
      bus.rx_empty = 1'($urandom);
      bus.tx_full = 1'($urandom);
      cyc("err_dphase", 1'b0, 1'b0, '0);
      cyc("err_first", 1'b0, 1'b1, '0);
      cyc("err_second", 1'b1, 1'b1, '0);
    end else begin
      for (int k = 0; k < int'(pend.stall); k++) begin
        bus.rx_empty = pend.w ? 1'($urandom) : 1'b1;
        bus.tx_full = pend.w ? 1'b1 : 1'($urandom);
        cyc("wait", 1'b0, 1'b0, '0);
      end
      bus.rx_empty = (pend.a[6] || pend.w) ? 1'($urandom) : 1'b0;
      bus.tx_full = (pend.a[6] || !pend.w) ? 1'($urandom) : 1'b0;
      cyc("complete", 1'b1, 1'b0, e);
    end
    pend = n;
  endtask

  initial begin
    pend = '0;
    {bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite, bus.rx_empty, bus.tx_full} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hready_out", 9'(bus.hready_out), 9'd1);
    chk("reset hresp", 9'(bus.hresp), 9'd0);
    chk("reset strobes", strobes, 9'd0);
    n_rst = 1'b1;
    issue(mk(7'h40, 3'd0, 1'b0, 3'd0));
    issue(mk(7'h41, 3'd0, 1'b0, 3'd0));
    issue(mk(7'h40, 3'd2, 1'b0, 3'd0));
    issue(mk(7'h41, 3'd1, 1'b0, 3'd0));
    issue(mk(7'h48, 3'd0, 1'b1, 3'd0));
    issue(mk(7'h44, 3'd0, 1'b1, 3'd0));
    issue(mk(7'h00, 3'd0, 1'b0, 3'd3));
    issue(mk(7'h04, 3'd2, 1'b1, 3'd2));
    issue(mk(7'h48, 3'd0, 1'b0, 3'd0));
    issue(mk(7'h44, 3'd0, 1'b0, 3'd0));
    issue(mk(7'h46, 3'd1, 1'b0, 3'd0));
    issue('0);
    for (int i = 0; i < 80; i++) begin
      xfer_t t;
      t.v = $urandom_range(0, 3) != 0;
      t.a = $urandom_range(0, 1) ? {1'b1, 6'($urandom_range(0, 11))} : 7'($urandom);
      t.s = $urandom_range(0, 7) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      t.w = 1'($urandom);
      t.stall = t.a[6] ? 3'd0 : 3'($urandom_range(0, 3));
      issue(t);
    end
    issue('0);
    issue(mk(7'h00, 3'd0, 1'b0, 3'd7));
    bus.hsel = 1'b0;
    bus.rx_empty = 1'b1;
    #2;
    chk("stall hready_out", 9'(bus.hready_out), 9'd0);
    @(posedge clk);
    #2;
    chk("wait hready_out", 9'(bus.hready_out), 9'd0);
    n_rst = 1'b0;
    #1;
    chk("midreset hready_out", 9'(bus.hready_out), 9'd1);
    chk("midreset hresp", 9'(bus.hresp), 9'd0);
    bus.rx_empty = 1'b0;
    #1;
    chk("midreset strobes", strobes, 9'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    pend = '0;
    issue('0);
    issue('0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
